// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the IMEM program loader: FSM state encoding and stream framing constants.
package imem_program_loader_pkg;

  localparam int unsigned LOAD_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } load_state_t;

endpackage

// File: rtl/imem_program_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: collects LOAD_BYTES_PER_WORD bytes and emits a registered
// word with a one-cycle word_valid pulse in the cycle after the final byte.
module byte_word_packer
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   byte_en,
  input  logic [7:0]             byte_data,
  output logic [1:0]             byte_idx,
  output logic                   word_valid,
  output logic [INSTR_WIDTH-1:0] word
);

  logic [INSTR_WIDTH-9:0] partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= '0;
      partial    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        partial  <= '0;
      end else if (byte_en) begin
        if (byte_idx == 2'(LOAD_BYTES_PER_WORD - 1)) begin
          // Final byte goes straight into the output word, lower bytes come from partial.
          word       <= {byte_data, partial};
          word_valid <= 1'b1;
          byte_idx   <= '0;
          partial    <= '0;
        end else begin
          case (byte_idx)
            2'd0:    partial[7:0]   <= byte_data;
            2'd1:    partial[15:8]  <= byte_data;
            default: partial[23:16] <= byte_data;
          endcase
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Length-prefixed byte-stream loader that writes packed 32-bit words into IMEM from address 0.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                   CPU_clk,
  input  logic                   CPU_rst,
  input  logic                   Load_Start,
  input  logic [7:0]             Byte_Data,
  input  logic                   Byte_Valid,
  output logic                   Byte_Ready,
  output logic                   IMEM_WE,
  output logic [ADDR_WIDTH-1:0]  IMEM_WAddr,
  output logic [INSTR_WIDTH-1:0] IMEM_WData,
  output logic                   Load_Busy,
  output logic                   Load_Done,
  output logic                   Load_Error,
  output logic [ADDR_WIDTH:0]    Words_Loaded
);

  load_state_t            state, state_nxt;
  logic [7:0]             len_lo;
  logic [15:0]            word_count;
  logic [ADDR_WIDTH:0]    words_loaded;
  logic                   data_last;
  logic                   load_error;
  logic                   byte_fire;
  logic                   start_ok;
  logic                   data_byte;
  logic                   final_byte;
  logic [15:0]            len_rx;
  logic [1:0]             byte_idx;
  logic                   word_valid;
  logic [INSTR_WIDTH-1:0] packed_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             checksum;
`endif

  assign byte_fire  = Byte_Valid & Byte_Ready;
  assign start_ok   = Load_Start && (state == ST_IDLE);
  assign data_byte  = byte_fire && (state == ST_DATA);
  assign len_rx     = {Byte_Data, len_lo};
  assign final_byte = data_byte && (byte_idx == 2'(LOAD_BYTES_PER_WORD - 1)) &&
                      ((16'(words_loaded) + 16'd1) == word_count);

  byte_word_packer #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_packer (
    .clk        (CPU_clk),
    .rst        (CPU_rst),
    .clear      (start_ok),
    .byte_en    (data_byte),
    .byte_data  (Byte_Data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word       (packed_word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (Load_Start) state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (byte_fire)  state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (byte_fire) begin
          if (len_rx == 16'd0)                      state_nxt = ST_DONE;
          else if ({16'd0, len_rx} > IMEM_DEPTH)    state_nxt = ST_ERR;
          else                                      state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid && data_last) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = ST_CHK;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (byte_fire) state_nxt = (Byte_Data == checksum) ? ST_DONE : ST_ERR;
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CPU_clk or posedge CPU_rst) begin
    if (CPU_rst) begin
      state        <= ST_IDLE;
      len_lo       <= '0;
      word_count   <= '0;
      words_loaded <= '0;
      data_last    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        load_error   <= 1'b0;
        words_loaded <= '0;
        word_count   <= '0;
        data_last    <= 1'b0;
      end else begin
        if (byte_fire && (state == ST_LEN_LO)) len_lo     <= Byte_Data;
        if (byte_fire && (state == ST_LEN_HI)) word_count <= len_rx;
        // data_last stalls the stream until the last word's write cycle has retired.
        if (final_byte) data_last <= 1'b1;
        if (word_valid) begin
          words_loaded <= words_loaded + 1'b1;
          if (data_last) data_last <= 1'b0;
        end
        if (state_nxt == ST_ERR) load_error <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CPU_clk or posedge CPU_rst) begin
    if (CPU_rst)        checksum <= '0;
    else if (start_ok)  checksum <= '0;
    else if (data_byte) checksum <= checksum ^ Byte_Data;
  end
`endif

  always_comb begin
    Byte_Ready = 1'b0;
    Load_Busy  = 1'b0;
    case (state)
      ST_LEN_LO, ST_LEN_HI: begin
        Byte_Ready = 1'b1;
        Load_Busy  = 1'b1;
      end
      ST_DATA: begin
        Byte_Ready = ~data_last;
        Load_Busy  = 1'b1;
      end
      ST_CHK: begin
        Byte_Ready = 1'b1;
        Load_Busy  = 1'b1;
      end
      default: begin
        Byte_Ready = 1'b0;
        Load_Busy  = 1'b0;
      end
    endcase
  end

  assign Load_Done    = (state == ST_DONE);
  assign Load_Error   = load_error;
  assign IMEM_WE      = word_valid;
  assign IMEM_WAddr   = words_loaded[ADDR_WIDTH-1:0];
  assign IMEM_WData   = packed_word;
  assign Words_Loaded = words_loaded;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed self-checking bench for imem_program_loader (checksum cases under LOADER_CHECKSUM_EN).
module tb_imem_program_loader;

  logic        CPU_clk = 1'b0;
  logic        CPU_rst;
  logic        Load_Start;
  logic [7:0]  Byte_Data;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        IMEM_WE;
  logic [7:0]  IMEM_WAddr;
  logic [31:0] IMEM_WData;
  logic        Load_Busy;
  logic        Load_Done;
  logic        Load_Error;
  logic [8:0]  Words_Loaded;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int base_w;
  int base_d;
  logic [7:0] prog1 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00};

  imem_program_loader #(
    .INSTR_WIDTH (32),
    .IMEM_DEPTH  (256),
    .ADDR_WIDTH  (8)
  ) dut (
    .CPU_clk      (CPU_clk),
    .CPU_rst      (CPU_rst),
    .Load_Start   (Load_Start),
    .Byte_Data    (Byte_Data),
    .Byte_Valid   (Byte_Valid),
    .Byte_Ready   (Byte_Ready),
    .IMEM_WE      (IMEM_WE),
    .IMEM_WAddr   (IMEM_WAddr),
    .IMEM_WData   (IMEM_WData),
    .Load_Busy    (Load_Busy),
    .Load_Done    (Load_Done),
    .Load_Error   (Load_Error),
    .Words_Loaded (Words_Loaded)
  );

  always #5 CPU_clk = ~CPU_clk;

  always @(negedge CPU_clk) begin
    if (IMEM_WE) begin
      wr_addr.push_back(IMEM_WAddr);
      wr_data.push_back(IMEM_WData);
    end
    if (Load_Done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CPU_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    Byte_Data  = b;
    Byte_Valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (Byte_Ready) ok = 1'b1;
      tick();
    end
    Byte_Valid = 1'b0;
    check("byte_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_start();
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b == 8'hFF) tick();
`endif
  endtask

  task automatic check_prog1(input string tag);
    check({tag, "_writes"}, wr_addr.size() - base_w, 2);
    check({tag, "_addr0"}, {24'd0, wr_addr[base_w]}, 32'd0);
    check({tag, "_data0"}, wr_data[base_w], 32'h0000_0013);
    check({tag, "_addr1"}, {24'd0, wr_addr[base_w+1]}, 32'd1);
    check({tag, "_data1"}, wr_data[base_w+1], 32'h0010_0093);
    check({tag, "_done"}, done_cnt - base_d, 1);
    check({tag, "_words"}, {23'd0, Words_Loaded}, 32'd2);
    check({tag, "_busy"}, {31'd0, Load_Busy}, 32'd0);
    check({tag, "_err"}, {31'd0, Load_Error}, 32'd0);
  endtask

  initial begin
    CPU_rst    = 1'b1;
    Load_Start = 1'b0;
    Byte_Data  = 8'h00;
    Byte_Valid = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'd0, Byte_Ready}, 32'd0);
    check("rst_we",    {31'd0, IMEM_WE}, 32'd0);
    check("rst_busy",  {31'd0, Load_Busy}, 32'd0);
    check("rst_done",  {31'd0, Load_Done}, 32'd0);
    check("rst_err",   {31'd0, Load_Error}, 32'd0);
    check("rst_words", {23'd0, Words_Loaded}, 32'd0);
    check("rst_waddr", {24'd0, IMEM_WAddr}, 32'd0);
    check("rst_wdata", IMEM_WData, 32'd0);
    CPU_rst = 1'b0;
    tick();

    // Case 1: two-word program, back-to-back bytes
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    check("t1_busy_start",  {31'd0, Load_Busy}, 32'd1);
    check("t1_ready_start", {31'd0, Byte_Ready}, 32'd1);
    for (int i = 0; i < 6; i++) send_byte(prog1[i]);
    check("t1_we_lat",    {31'd0, IMEM_WE}, 32'd1);
    check("t1_waddr_lat", {24'd0, IMEM_WAddr}, 32'd0);
    check("t1_wdata_lat", IMEM_WData, 32'h0000_0013);
    for (int i = 6; i < 10; i++) send_byte(prog1[i]);
    send_chk(8'h90);
    repeat (4) tick();
    check_prog1("t1");

    // Case 2: zero-length program
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check("t2_done_now", {31'd0, Load_Done}, 32'd1);
    check("t2_busy_now", {31'd0, Load_Busy}, 32'd0);
    tick();
    check("t2_done_drop", {31'd0, Load_Done}, 32'd0);
    repeat (2) tick();
    check("t2_writes", wr_addr.size() - base_w, 0);
    check("t2_done",   done_cnt - base_d, 1);
    check("t2_err",    {31'd0, Load_Error}, 32'd0);
    check("t2_words",  {23'd0, Words_Loaded}, 32'd0);

    // Case 3: oversize length 257
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    check("t3_err_now", {31'd0, Load_Error}, 32'd1);
    check("t3_busy",    {31'd0, Load_Busy}, 32'd0);
    repeat (3) tick();
    check("t3_err_sticky", {31'd0, Load_Error}, 32'd1);
    check("t3_writes", wr_addr.size() - base_w, 0);
    check("t3_done",   done_cnt - base_d, 0);
    pulse_start();
    check("t3_err_clr",  {31'd0, Load_Error}, 32'd0);
    check("t3_busy_new", {31'd0, Load_Busy}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (2) tick();

    // Case 4: valid gaps and Start pulses while busy
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(prog1[i]);
      if (i == 1) pulse_start();
      if (i == 5) begin
        pulse_start();
        check("t4_words_mid", {23'd0, Words_Loaded}, 32'd1);
        check("t4_busy_mid",  {31'd0, Load_Busy}, 32'd1);
      end
    end
    send_chk(8'h90);
    repeat (4) tick();
    check_prog1("t4");

    // Case 5: reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(prog1[i]);
    CPU_rst = 1'b1;
    #1;
    check("t5_we",    {31'd0, IMEM_WE}, 32'd0);
    check("t5_busy",  {31'd0, Load_Busy}, 32'd0);
    check("t5_ready", {31'd0, Byte_Ready}, 32'd0);
    check("t5_words", {23'd0, Words_Loaded}, 32'd0);
    tick();
    CPU_rst = 1'b0;
    tick();
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(prog1[i]);
    send_chk(8'h90);
    repeat (4) tick();
    check_prog1("t5");

    // Full-depth load: words 0..255, word i holds value i
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    send_chk(8'h00);
    repeat (4) tick();
    check("t7_writes", wr_addr.size() - base_w, 256);
    check("t7_addr_last", {24'd0, wr_addr[base_w+255]}, 32'd255);
    check("t7_data_last", wr_data[base_w+255], 32'h0000_00FF);
    check("t7_words", {23'd0, Words_Loaded}, 32'd256);
    check("t7_done",  done_cnt - base_d, 1);
    check("t7_err",   {31'd0, Load_Error}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum mismatch: words still written, error flagged
    base_w = wr_addr.size();
    base_d = done_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(prog1[i]);
    send_byte(8'h81);
    repeat (3) tick();
    check("t6_err",    {31'd0, Load_Error}, 32'd1);
    check("t6_done",   done_cnt - base_d, 0);
    check("t6_writes", wr_addr.size() - base_w, 2);
    check("t6_data1",  wr_data[base_w+1], 32'h0010_0093);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
